// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the ID/EX register (master) and the
// iterative multiply/divide unit (slave).
interface ex_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [1:0]       op_i;
   logic [WIDTH-1:0] rs_i;
   logic [WIDTH-1:0] rt_i;
   logic             flush_i;
   logic             stall_o;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_i, op_i, rs_i, rt_i, flush_i,
      input  stall_o, busy_o, done_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, rs_i, rt_i, flush_i,
      output stall_o, busy_o, done_o, hi_o, lo_o
   );
endinterface

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide: WIDTH-step shift-add multiply or
// restoring divide on operand magnitudes, sign fixed up when results commit.
//
// state  | meaning
// IDLE   | waiting for start_i; launches the operation in the same cycle
// MUL    | one shift-add step per cycle, WIDTH steps
// DIV    | one restoring divide step per cycle, WIDTH steps
// DONE   | hi_o/lo_o just committed, done_o high for this cycle
module ex_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   ex_muldiv_if.slave  md
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic                 stall;
   logic                 last_iter;

   logic [CW-1:0]        count_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]     b_q;
   logic [WIDTH-1:0]     rs_raw_q;
   logic                 neg_q_q;
   logic                 neg_r_q;
   logic                 busy_q;
   logic                 done_q;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;

   logic [WIDTH-1:0]     rs_abs;
   logic [WIDTH-1:0]     rt_abs;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [2*WIDTH-1:0]   prod_res;
   logic [WIDTH:0]       div_diff;
   logic                 div_ge;
   logic [WIDTH-1:0]     rem_new;
   logic [2*WIDTH-1:0]   div_next;
   logic [WIDTH-1:0]     quo_fin;
   logic [WIDTH-1:0]     rem_fin;
   logic [WIDTH-1:0]     res_hi;
   logic [WIDTH-1:0]     res_lo;

   assign last_iter = (count_q == CW'(WIDTH - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (md.start_i && !md.flush_i) begin
               stall   = 1'b1;
               state_d = md.op_i[1] ? S_DIV : S_MUL;
            end
         end
         S_MUL, S_DIV: begin
            if (md.flush_i) begin
               state_d = S_IDLE;
            end else begin
               stall = 1'b1;
               if (last_iter) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // Same instruction is still in EX; start_i here must not relaunch.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Negating the most negative value yields itself, read as unsigned magnitude.
   assign rs_abs = (md.op_i[0] && md.rs_i[WIDTH-1]) ? -md.rs_i : md.rs_i;
   assign rt_abs = (md.op_i[0] && md.rt_i[WIDTH-1]) ? -md.rt_i : md.rt_i;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   assign prod_res = neg_q_q ? -mul_next : mul_next;

   // Divide: acc = {remainder, dividend/quotient}. Remainder stays below the
   // divisor, so bit WIDTH of the difference is a valid sign bit.
   assign div_diff = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
   assign div_ge   = ~div_diff[WIDTH];
   assign rem_new  = div_ge ? div_diff[WIDTH-1:0] : {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};
   assign div_next = {rem_new, acc_q[WIDTH-2:0], div_ge};
   assign quo_fin  = neg_q_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
   assign rem_fin  = neg_r_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

   always_comb begin
      res_hi = prod_res[2*WIDTH-1:WIDTH];
      res_lo = prod_res[WIDTH-1:0];
      if (state_q == S_DIV) begin
         if (b_q == '0) begin
            res_hi = rs_raw_q;
            res_lo = '1;
         end else begin
            res_hi = rem_fin;
            res_lo = quo_fin;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q  <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         rs_raw_q <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         busy_q <= (state_d == S_MUL) || (state_d == S_DIV);
         done_q <= (state_d == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (state_d != S_IDLE) begin
                  count_q  <= '0;
                  rs_raw_q <= md.rs_i;
                  neg_q_q  <= md.op_i[0] & (md.rs_i[WIDTH-1] ^ md.rt_i[WIDTH-1]);
                  neg_r_q  <= md.op_i[0] & md.rs_i[WIDTH-1];
                  if (md.op_i[1]) begin
                     acc_q <= {{WIDTH{1'b0}}, rs_abs};
                     b_q   <= rt_abs;
                  end else begin
                     acc_q <= {{WIDTH{1'b0}}, rt_abs};
                     b_q   <= rs_abs;
                  end
               end
            end
            S_MUL, S_DIV: begin
               if (state_d == S_DONE) begin
                  hi_q <= res_hi;
                  lo_q <= res_lo;
               end else if (state_d != S_IDLE) begin
                  acc_q   <= (state_q == S_DIV) ? div_next : mul_next;
                  count_q <= count_q + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign md.stall_o = stall;
   assign md.busy_o  = busy_q;
   assign md.done_o  = done_q;
   assign md.hi_o    = hi_q;
   assign md.lo_o    = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed vectors plus flush/reset/back-to-back sequences for ex_muldiv.
module tb_ex_muldiv;
   localparam int WIDTH = 32;
   localparam int NV    = 14;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ex_muldiv_if #(.WIDTH(WIDTH)) bus ();

   ex_muldiv #(.WIDTH(WIDTH)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .md    (bus.slave)
   );

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs [NV];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input string name, input logic [1:0] op,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] hi, input logic [31:0] lo);
      vecs[i].name = name;
      vecs[i].op   = op;
      vecs[i].rs   = rs;
      vecs[i].rt   = rt;
      vecs[i].hi   = hi;
      vecs[i].lo   = lo;
   endtask

   // Entered at posedge+1 of the launch cycle; leaves at posedge+1 of the
   // cycle after DONE.
   task automatic run_op(input string name, input logic [1:0] op,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input bit keep_start);
      int done_cyc;
      int bad;
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.rs_i    = rs;
      bus.rt_i    = rt;
      #1;
      chk({name, " stall_c0"}, bus.stall_o, 1);
      done_cyc = -1;
      bad      = 0;
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
         @(posedge clk);
         #1;
         if (bus.done_o) done_cyc = c;
         else if (!(bus.stall_o && bus.busy_o)) bad++;
      end
      chk({name, " done_latency"}, done_cyc, WIDTH + 1);
      chk({name, " iter_stall_busy"}, bad, 0);
      chk({name, " stall_done"}, bus.stall_o, 0);
      chk({name, " hi"}, bus.hi_o, hi);
      chk({name, " lo"}, bus.lo_o, lo);
      if (!keep_start) bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      chk({name, " done_pulse"}, bus.done_o, 0);
      chk({name, " busy_after"}, bus.busy_o, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcount;

      set_vec(0,  "multu_max",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      set_vec(1,  "mult_m3x7",    2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
      set_vec(2,  "div_m7_2",     2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      set_vec(3,  "divu_100_0",   2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF);
      set_vec(4,  "div_min_m1",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      set_vec(5,  "multu_6x7",    2'b00, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A);
      set_vec(6,  "div_m7_0",     2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
      set_vec(7,  "mult_min_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      set_vec(8,  "mult_min_1",   2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000);
      set_vec(9,  "div_7_m2",     2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      set_vec(10, "divu_max_1",   2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF);
      set_vec(11, "multu_shift",  2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
      set_vec(12, "divu_5_9",     2'b10, 32'h00000005, 32'h00000009, 32'h00000005, 32'h00000000);
      set_vec(13, "divu_100_7",   2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);

      rst         = 1'b1;
      bus.start_i = 1'b0;
      bus.op_i    = 2'b00;
      bus.rs_i    = '0;
      bus.rt_i    = '0;
      bus.flush_i = 1'b0;
      #12;
      chk("reset hi", bus.hi_o, 0);
      chk("reset lo", bus.lo_o, 0);
      chk("reset done", bus.done_o, 0);
      chk("reset busy", bus.busy_o, 0);
      chk("reset stall", bus.stall_o, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, 1'b0);
      end

      // Flush in cycle 10 of a MULT; previous results (hi=2, lo=14) must survive.
      bus.start_i = 1'b1;
      bus.op_i    = 2'b01;
      bus.rs_i    = 32'hFFFFFFFD;
      bus.rt_i    = 32'h00000007;
      #1;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      bus.flush_i = 1'b1;
      #1;
      chk("flush stall_c10", bus.stall_o, 0);
      chk("flush busy_c10", bus.busy_o, 1);
      @(posedge clk);
      #1;
      chk("flush busy_c11", bus.busy_o, 0);
      chk("flush done_c11", bus.done_o, 0);
      chk("flush hi_kept", bus.hi_o, 32'h00000002);
      chk("flush lo_kept", bus.lo_o, 32'h0000000E);
      bus.flush_i = 1'b0;
      bus.start_i = 1'b0;
      dcount = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done_o) dcount++;
      end
      chk("flush no_done", dcount, 0);

      // Reset pulsed in cycle 15 of a DIVU.
      bus.start_i = 1'b1;
      bus.op_i    = 2'b10;
      bus.rs_i    = 32'h00000064;
      bus.rt_i    = 32'h00000007;
      #1;
      repeat (15) begin
         @(posedge clk);
         #1;
      end
      rst         = 1'b1;
      bus.start_i = 1'b0;
      #1;
      chk("rst hi", bus.hi_o, 0);
      chk("rst lo", bus.lo_o, 0);
      chk("rst done", bus.done_o, 0);
      chk("rst busy", bus.busy_o, 0);
      chk("rst stall", bus.stall_o, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_op("post_rst_multu_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

      // start_i held through DONE, then a back-to-back MULTU launched in cycle 34.
      run_op("hold_multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
      run_op("b2b_multu_3x5", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage. It consumes the RS/RT operands and decoded operation delivered by the ID/EX pipeline register, and produces a 64-bit HI/LO result. While a 32-iteration shift-add multiply or restoring divide is in progress, it holds the front of the pipeline with a stall. It is the consumer-side counterpart of the ID/EX register: that register launches operands, and this block accepts them, iterates, and reports completion.

## Interface
Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous and active-high.
- start_i  input  1  EX instruction is MULT/MULTU/DIV/DIVU; level from the ID/EX register.
- op_i  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rs_i  input  WIDTH  RSdata from ID/EX; multiplicand or dividend.
- rt_i  input  WIDTH  RTdata from ID/EX; multiplier or divisor.
- flush_i  input  1  abort any operation in progress (branch/jump flush).
- stall_o  output  1  hold PC, IF/ID and ID/EX; combinational.
- busy_o  output  1  high in MUL or DIV state; registered.
- done_o  output  1  one-cycle completion pulse; registered.
- hi_o  output  WIDTH  HI register: product upper half, or remainder.
- lo_o  output  WIDTH  LO register: product lower half, or quotient.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset forces IDLE with count=0, hi_o=0, lo_o=0, done_o=0, busy_o=0.
- IDLE: if start_i=1 and flush_i=0, latch the operands and go to MUL (op_i[1]=0) or DIV (op_i[1]=1) with count=0.
  - Signed ops (op_i[0]=1) latch |rs_i| and |rt_i|, and record neg_q = rs[31]^rt[31] and neg_r = rs[31].
  - Unsigned ops clear both flags.
  - |0x80000000| is treated as unsigned 0x80000000.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator. After count=WIDTH-1, go to DONE.
- DIV: one restoring step per cycle: shift the remainder left, subtract the divisor, keep the result if it is non-negative, and shift the quotient bit in. After count=WIDTH-1, go to DONE.
- Entering DONE writes hi_o/lo_o.
  - MUL: the product, two's-complement negated across 64 bits if neg_q.
  - DIV: lo = quotient (negated if neg_q), hi = remainder (negated if neg_r).
  - Divide by zero (latched divisor 0), both DIV and DIVU: lo=0xFFFFFFFF, hi=rs_i as latched (original signed value). Latency is unchanged.
- DONE: done_o=1 for this cycle only, then unconditional return to IDLE. start_i is ignored in DONE, because the same instruction is still in EX and leaves at this edge.
- stall_o = (state==IDLE and start_i and not flush_i) or state==MUL or state==DIV.
- flush_i in MUL/DIV: return to IDLE next edge. hi_o/lo_o are unchanged, no done_o, and stall_o drops combinationally in that cycle.
- flush_i in DONE: has no effect; the results are already committed.
- hi_o/lo_o change only on entry to DONE or on reset.

## Timing
- Cycle 0: start_i high in IDLE; stall_o=1 combinationally.
- Cycles 1..WIDTH: iteration cycles; stall_o=1 and busy_o=1.
- Cycle WIDTH+1: DONE; hi_o/lo_o valid, done_o=1, stall_o=0.
- Total stall is WIDTH+1 cycles (33 at default). The next instruction may assert start_i in cycle WIDTH+2.
- Reset asserted mid-operation immediately clears all state and outputs; no done_o is produced for the aborted operation.
- No combinational path from rs_i/rt_i to any output.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001; done_o only in cycle 33; stall_o high cycles 0..32.
- MULT -3 × 7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB. DIV -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIVU 100 / 0 -> lo_o=0xFFFFFFFF, hi_o=0x00000064 after 33 cycles. DIV 0x80000000 / -1 -> lo_o=0x80000000, hi_o=0.
- flush_i in cycle 10 of a MULT -> IDLE next cycle; hi_o/lo_o keep the previous values; no done_o; stall_o=0 in cycle 10.
- rst_i pulsed in cycle 15 of a DIVU -> all outputs 0 asynchronously; a subsequent MULTU 6×7 gives lo_o=42, hi_o=0.
- start_i held high through DONE -> exactly one operation and one done_o. Back-to-back MULTU starting in cycle 34 completes in cycle 67.
